// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU
// memory stage (default priority) and a DMA/debug loader port.
// Ports: clk, reset (sync, active-high); cpu_req/we/addr/wdata in,
// cpu_rdata/cpu_stall out; dma_req/we/addr/wdata in, dma_rdata and
// dma_ack out; mem_we/addr/wdata to the array, mem_rdata back (async).
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW =
    (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic {
    S_RUN,
    S_ACK
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          dma_elig;
  logic          dma_grant;
  logic          cpu_grant;

  // The ack cycle blocks a held dma_req from being granted twice.
  always_comb begin
    dma_elig  = dma_req & (state == S_RUN) & ~reset;
    dma_grant = dma_elig &
                (~cpu_req | (wait_cnt >= WAIT_MAX));
    cpu_grant = cpu_req & ~dma_grant & ~reset;
  end

  assign cpu_stall = cpu_req & dma_grant;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    if (dma_grant) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_grant & cpu_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      dma_ack   <= 1'b0;
      dma_rdata <= '0;
    end else begin
      dma_ack <= dma_grant;
      if (dma_grant) begin
        state     <= S_ACK;
        dma_rdata <= mem_rdata;
        wait_cnt  <= '0;
      end else begin
        state <= S_RUN;
        // Count only cycles where DMA could have won but lost;
        // the ack cycle leaves the count untouched.
        if (!dma_req) begin
          wait_cnt <= '0;
        end else if (dma_elig && (wait_cnt < WAIT_MAX)) begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized checks of dmem_arbiter
// (MAX_WAIT = 4 and MAX_WAIT = 0 instances) against a reference model.
module tb_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;

  logic          dma_req   [2];
  logic          dma_we    [2];
  logic [AW-1:0] dma_addr  [2];
  logic [DW-1:0] dma_wdata [2];
  logic [DW-1:0] cpu_rdata [2];
  logic          cpu_stall [2];
  logic [DW-1:0] dma_rdata [2];
  logic          dma_ack   [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  logic [DW-1:0] mem0 [1024];
  logic [DW-1:0] mem1 [1024];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
    .dma_req(dma_req[0]), .dma_we(dma_we[0]),
    .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
    .dma_rdata(dma_rdata[0]), .dma_ack(dma_ack[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
    .dma_req(dma_req[1]), .dma_we(dma_we[1]),
    .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
    .dma_rdata(dma_rdata[1]), .dma_ack(dma_ack[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Data memory arrays, one per instance.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (mem_we[0]) mem0[mem_addr[0]] <= mem_wdata[0];
      if (mem_we[1]) mem1[mem_addr[1]] <= mem_wdata[1];
    end
  end

  always_comb begin
    mem_rdata[0] = mem0[mem_addr[0]];
    mem_rdata[1] = mem1[mem_addr[1]];
  end

  // Reference model state
  int            mw [2] = '{4, 0};
  bit            m_ack [2];
  bit            acked [2];
  int            m_den [2];
  logic [DW-1:0] m_rd [2];
  bit            m_rdk [2];
  logic [DW-1:0] rmem [2][1024];
  int            n_we [2];
  int            n_stall [2];
  int            n_ack [2];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle of the arbitration rules for both instances.
  task automatic model();
    for (int k = 0; k < 2; k++) begin
      bit            elig;
      bit            gnt;
      bit            cg;
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      elig = dma_req[k] && !m_ack[k] && !reset;
      gnt  = elig && (!cpu_req || m_den[k] >= mw[k]);
      cg   = cpu_req && !gnt && !reset;
      we   = gnt ? dma_we[k] : (cg && cpu_we);
      a    = gnt ? dma_addr[k] : cpu_addr;
      wd   = gnt ? dma_wdata[k] : cpu_wdata;
      check($sformatf("stall%0d", k),
            32'(cpu_stall[k]), 32'(cpu_req && gnt));
      check($sformatf("ack%0d", k),
            32'(dma_ack[k]), 32'(m_ack[k]));
      check($sformatf("mem_we%0d", k),
            32'(mem_we[k]), 32'(we));
      check($sformatf("mem_addr%0d", k),
            32'(mem_addr[k]), 32'(a));
      if (we)
        check($sformatf("mem_wdata%0d", k), mem_wdata[k], wd);
      if (m_rdk[k])
        check($sformatf("dma_rdata%0d", k), dma_rdata[k], m_rd[k]);
      if (cg && !cpu_we)
        check($sformatf("cpu_rdata%0d", k),
              cpu_rdata[k], rmem[k][cpu_addr]);
      n_we[k]    += int'(mem_we[k] === 1'b1);
      n_stall[k] += int'(cpu_stall[k] === 1'b1);
      n_ack[k]   += int'(dma_ack[k] === 1'b1);
      acked[k] = m_ack[k];
      if (gnt) begin
        m_rd[k]  = rmem[k][a];
        m_rdk[k] = !dma_we[k];
      end
      if (reset) begin
        m_rd[k]  = '0;
        m_rdk[k] = 1'b1;
      end
      if (we) rmem[k][a] = wd;
      if (gnt || !dma_req[k] || reset)
        m_den[k] = 0;
      else if (elig)
        m_den[k] = (m_den[k] + 1 > mw[k]) ? mw[k] : m_den[k] + 1;
      m_ack[k] = gnt;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic dma_new(int k);
    dma_req[k]   = 1'b1;
    dma_we[k]    = 1'($urandom_range(0, 1));
    dma_addr[k]  = AW'($urandom_range(0, 31));
    dma_wdata[k] = $urandom;
  endtask

  initial begin
    clr = 1'b1;
    reset = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      dma_req[k] = 1'b0;
      dma_we[k] = 1'b0;
      dma_addr[k] = '0;
      dma_wdata[k] = '0;
      m_ack[k] = 1'b0;
      m_den[k] = 0;
      m_rd[k] = '0;
      m_rdk[k] = 1'b1;
      for (int i = 0; i < 1024; i++) rmem[k][i] = '0;
    end
    adv();
    clr = 1'b0;

    // reset state
    settle();
    check("rst_ack", 32'(dma_ack[0]), 32'd0);
    check("rst_rdata", dma_rdata[0], 32'd0);
    check("rst_we", 32'(mem_we[0]), 32'd0);
    adv();
    reset = 1'b0;

    // CPU store then load
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 10'd5; cpu_wdata = 32'hDEADBEEF;
    settle();
    check("t1_we", 32'(mem_we[0]), 32'd1);
    adv();
    cpu_we = 1'b0;
    settle();
    check("t1_rd", cpu_rdata[0], 32'hDEADBEEF);
    check("t1_stall", 32'(cpu_stall[0]), 32'd0);
    adv();
    cpu_req = 1'b0;

    // DMA write with CPU idle
    dma_req[0] = 1'b1; dma_we[0] = 1'b1;
    dma_addr[0] = 10'd12; dma_wdata[0] = 32'h00001234;
    settle();
    check("t2_we", 32'(mem_we[0]), 32'd1);
    check("t2_addr", 32'(mem_addr[0]), 32'd12);
    check("t2_ack0", 32'(dma_ack[0]), 32'd0);
    adv();
    settle();
    check("t2_ack1", 32'(dma_ack[0]), 32'd1);
    adv();
    dma_req[0] = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd12;
    settle();
    check("t2_rd", cpu_rdata[0], 32'h00001234);
    check("t2_ack2", 32'(dma_ack[0]), 32'd0);
    adv();

    // DMA read under CPU contention
    cpu_we = 1'b1; cpu_addr = 10'd3; cpu_wdata = 32'hCAFE0003;
    settle();
    adv();
    cpu_we = 1'b0; cpu_addr = 10'd20;
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 10'd3;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_nostall", 32'(cpu_stall[0]), 32'd0);
      adv();
    end
    settle();
    check("t3_stall", 32'(cpu_stall[0]), 32'd1);
    check("t3_addr", 32'(mem_addr[0]), 32'd3);
    adv();
    settle();
    check("t3_ack", 32'(dma_ack[0]), 32'd1);
    check("t3_rd", dma_rdata[0], 32'hCAFE0003);
    check("t3_cpu", 32'(cpu_stall[0]), 32'd0);
    adv();
    dma_req[0] = 1'b0;
    cpu_req = 1'b0;

    // dma_req held across the ack cycle
    n_we[0] = 0;
    dma_req[0] = 1'b1; dma_we[0] = 1'b1;
    dma_addr[0] = 10'd30; dma_wdata[0] = 32'hA1;
    settle();
    adv();
    settle();
    check("t4_ack", 32'(dma_ack[0]), 32'd1);
    check("t4_gap", 32'(mem_we[0]), 32'd0);
    adv();
    dma_addr[0] = 10'd31; dma_wdata[0] = 32'hA2;
    settle();
    check("t4_g2", 32'(mem_we[0]), 32'd1);
    adv();
    dma_req[0] = 1'b0;
    settle();
    adv();
    check("t4_pulses", 32'(n_we[0]), 32'd2);

    // reset in a DMA write grant cycle
    dma_req[0] = 1'b1; dma_we[0] = 1'b1;
    dma_addr[0] = 10'd7; dma_wdata[0] = 32'h55;
    reset = 1'b1;
    settle();
    check("t5_we", 32'(mem_we[0]), 32'd0);
    adv();
    reset = 1'b0;
    dma_req[0] = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd7;
    settle();
    check("t5_ack", 32'(dma_ack[0]), 32'd0);
    check("t5_mem7", cpu_rdata[0], 32'd0);
    adv();
    dma_req[0] = 1'b1; dma_we[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t5_wait", 32'(cpu_stall[0]), 32'd0);
      adv();
    end
    settle();
    check("t5_grant", 32'(cpu_stall[0]), 32'd1);
    adv();
    settle();
    adv();
    dma_req[0] = 1'b0;
    cpu_req = 1'b0;

    // MAX_WAIT = 0 instance: DMA preempts at once
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    dma_req[1] = 1'b1; dma_we[1] = 1'b0; dma_addr[1] = 10'd5;
    settle();
    check("t6_stall", 32'(cpu_stall[1]), 32'd1);
    check("t6_addr", 32'(mem_addr[1]), 32'd5);
    adv();
    settle();
    check("t6_ack", 32'(dma_ack[1]), 32'd1);
    check("t6_cpu", 32'(cpu_stall[1]), 32'd0);
    check("t6_rd", dma_rdata[1], 32'hDEADBEEF);
    adv();
    dma_req[1] = 1'b0;

    // sustained contention: one stall per MAX_WAIT+2 cycles
    n_stall[0] = 0;
    n_ack[0] = 0;
    cpu_addr = 10'd3;
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 10'd3;
    for (int i = 0; i < 12; i++) begin
      settle();
      adv();
    end
    check("cont_stall", 32'(n_stall[0]), 32'd2);
    check("cont_ack", 32'(n_ack[0]), 32'd2);
    dma_req[0] = 1'b0;
    cpu_req = 1'b0;
    settle();
    adv();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      cpu_req = ($urandom_range(0, 3) != 0);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = AW'($urandom_range(0, 31));
      cpu_wdata = $urandom;
      for (int k = 0; k < 2; k++)
        if (!dma_req[k] && $urandom_range(0, 2) == 0) dma_new(k);
      settle();
      adv();
      for (int k = 0; k < 2; k++) begin
        if (acked[k]) begin
          if ($urandom_range(0, 1) == 1) dma_new(k);
          else dma_req[k] = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
